// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: records cause and EPC in CP0, vectors to the handler and performs eret.
// Optional macro EXC_CTRL_IRQ_EN adds synchronized external interrupts.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] pc,
  input  logic        sys_req,
  input  logic        brk_req,
  input  logic        teq_req,
  input  logic        eret_req,
  input  logic [3:0]  irq,
  input  logic [3:0]  irq_mask,
  input  logic        int_en,
  input  logic [31:0] epc_in,
  output logic        cp0_exc,
  output logic [4:0]  cp0_cause,
  output logic [31:0] cp0_epc,
  output logic        cp0_eret,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_addr,
  output logic        busy,
  output logic        in_service
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    VECTOR = 2'd2,
    RETURN = 2'd3
  } state_t;

  localparam logic [4:0] CAUSE_INT  = 5'b00000;
  localparam logic [4:0] CAUSE_SYS  = 5'b01000;
  localparam logic [4:0] CAUSE_BRK  = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ  = 5'b01101;

  state_t      state_r, state_s;
  logic [4:0]  cause_r, cause_s;
  logic [31:0] epc_r, epc_s;
  logic        in_service_r, in_service_s;
  logic        irq_pend_s;

`ifdef EXC_CTRL_IRQ_EN
  logic [3:0] irq_meta_r;
  logic [3:0] irq_sync_r;

  // Two-flop synchronizer for the asynchronous interrupt lines; frozen while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_meta_r <= 4'b0000;
      irq_sync_r <= 4'b0000;
    end else if (ena) begin
      irq_meta_r <= irq;
      irq_sync_r <= irq_meta_r;
    end
  end

  assign irq_pend_s = (|(irq_sync_r & irq_mask)) & int_en & ~in_service_r;
`else
  logic unused_irq_s;
  assign unused_irq_s = ^{irq, irq_mask, int_en};
  assign irq_pend_s   = 1'b0;
`endif

  // State, latched cause/EPC and handler-active flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cause_r      <= 5'b00000;
      epc_r        <= 32'h0000_0000;
      in_service_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cause_r      <= cause_s;
      epc_r        <= epc_s;
      in_service_r <= in_service_s;
    end
  end

  // Next-state logic: synchronous exceptions outrank interrupts, which outrank eret.
  always_comb begin
    state_s      = state_r;
    cause_s      = cause_r;
    epc_s        = epc_r;
    in_service_s = in_service_r;
    if (ena) begin
      case (state_r)
        IDLE: begin
          if (brk_req) begin
            cause_s = CAUSE_BRK;
            epc_s   = pc;
            state_s = RECORD;
          end else if (sys_req) begin
            cause_s = CAUSE_SYS;
            epc_s   = pc;
            state_s = RECORD;
          end else if (teq_req) begin
            cause_s = CAUSE_TEQ;
            epc_s   = pc;
            state_s = RECORD;
          end else if (irq_pend_s) begin
            cause_s = CAUSE_INT;
            epc_s   = pc;
            state_s = RECORD;
          end else if (eret_req) begin
            state_s = RETURN;
          end else begin
            state_s = IDLE;
          end
        end
        RECORD: state_s = VECTOR;
        VECTOR: begin
          in_service_s = 1'b1;
          state_s      = IDLE;
        end
        RETURN: begin
          in_service_s = 1'b0;
          state_s      = IDLE;
        end
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Output decode from state; strobes are suppressed during a stall.
  always_comb begin
    cp0_exc       = 1'b0;
    cp0_cause     = 5'b00000;
    cp0_epc       = 32'h0000_0000;
    cp0_eret      = 1'b0;
    flush         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        flush = 1'b0;
      end
      RECORD: begin
        cp0_exc   = ena;
        cp0_cause = cause_r;
        cp0_epc   = epc_r;
        flush     = ena;
      end
      VECTOR: begin
        redirect      = ena;
        redirect_addr = EXC_VECTOR;
        flush         = ena;
      end
      RETURN: begin
        cp0_eret      = ena;
        redirect      = ena;
        redirect_addr = epc_in;
        flush         = ena;
      end
      default: begin
        flush = 1'b0;
      end
    endcase
  end

  assign busy       = (state_r != IDLE);
  assign in_service = in_service_r;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl; interrupt cases are built only with EXC_CTRL_IRQ_EN.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [31:0] pc;
  logic        sys_req, brk_req, teq_req, eret_req;
  logic [3:0]  irq, irq_mask;
  logic        int_en;
  logic [31:0] epc_in;
  logic        cp0_exc, cp0_eret, flush, redirect, busy, in_service;
  logic [4:0]  cp0_cause;
  logic [31:0] cp0_epc, redirect_addr;

  int total = 0;
  int bad   = 0;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .ena(ena), .pc(pc),
    .sys_req(sys_req), .brk_req(brk_req), .teq_req(teq_req), .eret_req(eret_req),
    .irq(irq), .irq_mask(irq_mask), .int_en(int_en), .epc_in(epc_in),
    .cp0_exc(cp0_exc), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc), .cp0_eret(cp0_eret),
    .flush(flush), .redirect(redirect), .redirect_addr(redirect_addr),
    .busy(busy), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    sys_req = 1'b0; brk_req = 1'b0; teq_req = 1'b0; eret_req = 1'b0;
  endtask

  logic seen;

  initial begin
    rst = 1'b1; ena = 1'b1; pc = 32'h0; epc_in = 32'h0;
    clear_reqs();
    irq = 4'b0000; irq_mask = 4'b0000; int_en = 1'b0;
    tick(); tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_exc", {31'b0, cp0_exc}, 32'd0);
    check("rst_redirect", {31'b0, redirect}, 32'd0);
    check("rst_in_service", {31'b0, in_service}, 32'd0);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_raddr", redirect_addr, 32'd0);
    rst = 1'b0;
    tick();

    // syscall: RECORD then VECTOR
    pc = 32'h0000_0040; sys_req = 1'b1;
    tick();
    clear_reqs(); pc = 32'h0;
    check("sys_exc", {31'b0, cp0_exc}, 32'd1);
    check("sys_cause", {27'b0, cp0_cause}, 32'h08);
    check("sys_epc", cp0_epc, 32'h40);
    check("sys_flush", {31'b0, flush}, 32'd1);
    check("sys_noredir", {31'b0, redirect}, 32'd0);
    tick();
    check("vec_redirect", {31'b0, redirect}, 32'd1);
    check("vec_addr", redirect_addr, 32'h4);
    check("vec_flush", {31'b0, flush}, 32'd1);
    check("vec_exc_off", {31'b0, cp0_exc}, 32'd0);
    check("vec_cause0", {27'b0, cp0_cause}, 32'd0);
    tick();
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_insvc", {31'b0, in_service}, 32'd1);
    check("idle_raddr", redirect_addr, 32'd0);

    // eret
    epc_in = 32'h0000_0044; eret_req = 1'b1;
    tick();
    clear_reqs();
    check("eret_strobe", {31'b0, cp0_eret}, 32'd1);
    check("eret_redirect", {31'b0, redirect}, 32'd1);
    check("eret_addr", redirect_addr, 32'h44);
    check("eret_flush", {31'b0, flush}, 32'd1);
    tick();
    check("eret_insvc_clr", {31'b0, in_service}, 32'd0);
    check("eret_off", {31'b0, cp0_eret}, 32'd0);

    // all three together: break wins, late teq ignored
    pc = 32'h0000_0100; brk_req = 1'b1; sys_req = 1'b1; teq_req = 1'b1;
    tick();
    clear_reqs(); teq_req = 1'b1;
    check("prio_cause", {27'b0, cp0_cause}, 32'h09);
    check("prio_epc", cp0_epc, 32'h100);
    tick();
    clear_reqs();
    tick();
    check("prio_single", {31'b0, busy}, 32'd0);
    check("prio_insvc", {31'b0, in_service}, 32'd1);

    // teq accepted while in service (nesting)
    pc = 32'h0000_0200; teq_req = 1'b1;
    tick();
    clear_reqs();
    check("teq_nest_exc", {31'b0, cp0_exc}, 32'd1);
    check("teq_cause", {27'b0, cp0_cause}, 32'h0D);
    tick(); tick();

    // exception and eret together: eret dropped
    pc = 32'h0000_0300; sys_req = 1'b1; eret_req = 1'b1;
    tick();
    clear_reqs();
    check("exc_eret_exc", {31'b0, cp0_exc}, 32'd1);
    check("exc_eret_noeret", {31'b0, cp0_eret}, 32'd0);
    tick(); tick();
    check("exc_eret_idle", {31'b0, busy}, 32'd0);

    // stall in RECORD
    pc = 32'h0000_0008; sys_req = 1'b1;
    tick();
    clear_reqs(); ena = 1'b0;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seen = seen | cp0_exc | flush | redirect | cp0_eret;
      tick();
    end
    check("stall_nostrobe", {31'b0, seen}, 32'd0);
    check("stall_busy", {31'b0, busy}, 32'd1);
    ena = 1'b1;
    #1;
    check("stall_resume_exc", {31'b0, cp0_exc}, 32'd1);
    check("stall_resume_epc", cp0_epc, 32'h8);
    tick();
    check("stall_once", {31'b0, cp0_exc}, 32'd0);
    check("stall_vec", {31'b0, redirect}, 32'd1);
    tick();

    // reset during VECTOR
    pc = 32'h0000_0010; sys_req = 1'b1;
    tick();
    clear_reqs();
    tick();
    check("rv_pre_redirect", {31'b0, redirect}, 32'd1);
    rst = 1'b1;
    #1;
    check("rv_redirect", {31'b0, redirect}, 32'd0);
    check("rv_busy", {31'b0, busy}, 32'd0);
    check("rv_insvc", {31'b0, in_service}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

`ifdef EXC_CTRL_IRQ_EN
    // interrupt accepted three cycles after assertion
    pc = 32'h0000_0500; irq = 4'b0010; irq_mask = 4'b0010; int_en = 1'b1;
    tick();
    check("irq_lat1", {31'b0, cp0_exc}, 32'd0);
    tick();
    check("irq_lat2", {31'b0, cp0_exc}, 32'd0);
    tick();
    check("irq_exc", {31'b0, cp0_exc}, 32'd1);
    check("irq_cause", {27'b0, cp0_cause}, 32'd0);
    check("irq_epc", cp0_epc, 32'h500);
    tick(); tick();
    check("irq_insvc", {31'b0, in_service}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | cp0_exc;
    end
    check("irq_blocked_insvc", {31'b0, seen}, 32'd0);
    irq_mask = 4'b0000; eret_req = 1'b1;
    tick();
    clear_reqs();
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | cp0_exc;
    end
    check("irq_masked", {31'b0, seen}, 32'd0);
    check("irq_masked_insvc", {31'b0, in_service}, 32'd0);
`else
    // interrupts are ignored in the default build
    irq = 4'b1111; irq_mask = 4'b1111; int_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | cp0_exc | busy;
    end
    check("irq_ignored", {31'b0, seen}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 The block SHALL have parameter EXC_VECTOR, default 32'h0000_0004, giving the exception handler entry address.
REQ-002 The block SHALL have these ports, one per line as: name  direction  width  meaning.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- ena  in  1  advance enable; low holds all state.
- pc  in  32  address of the instruction raising the request.
- sys_req  in  1  syscall decoded, 1-cycle pulse.
- brk_req  in  1  break decoded, 1-cycle pulse.
- teq_req  in  1  teq taken, 1-cycle pulse.
- eret_req  in  1  eret decoded, 1-cycle pulse.
- irq  in  4  external interrupt lines, level, asynchronous to clk.
- irq_mask  in  4  per-line interrupt enable, from Status[11:8].
- int_en  in  1  global interrupt enable, from Status[0].
- epc_in  in  32  current EPC value read from CP0.
- cp0_exc  out  1  1-cycle strobe to CP0 to record cause, EPC and shift Status.
- cp0_cause  out  5  cause code, valid while cp0_exc=1.
- cp0_epc  out  32  EPC value, valid while cp0_exc=1.
- cp0_eret  out  1  1-cycle strobe to CP0 to restore Status.
- flush  out  1  squash the younger pipeline instruction.
- redirect  out  1  load redirect_addr into PC this cycle.
- redirect_addr  out  32  next PC when redirect=1.
- busy  out  1  high whenever the FSM is not in IDLE.
- in_service  out  1  a handler is active (set at VECTOR, cleared at RETURN).

Function
REQ-003 The FSM SHALL have states IDLE, RECORD, VECTOR and RETURN, all transitions on posedge clk with ena=1.
REQ-004 In IDLE, the block SHALL sample requests with priority brk > sys > teq > interrupt; an interrupt is pending when (irq_sync & irq_mask) != 0, int_en=1 and in_service=0.
REQ-005 When a request is accepted in IDLE, the block SHALL latch cause (BREAK 5'b01001, SYSCALL 5'b01000, TEQ 5'b01101, INT 5'b00000) and pc, then go to RECORD.
REQ-006 In RECORD, the block SHALL drive cp0_exc=1, cp0_cause and cp0_epc from the latched values, and flush=1, for exactly one cycle, then go to VECTOR.
REQ-007 In VECTOR, the block SHALL drive redirect=1, redirect_addr=EXC_VECTOR and flush=1, set in_service, then go to IDLE; request-to-redirect latency is 2 cycles.
REQ-008 When eret_req=1 in IDLE with no exception or interrupt accepted, the block SHALL go to RETURN.
REQ-009 In RETURN, the block SHALL drive cp0_eret=1, redirect=1, redirect_addr=epc_in and flush=1, clear in_service, then go to IDLE.
REQ-010 When an exception and eret_req occur together in IDLE, the exception SHALL win and eret_req SHALL be dropped.
REQ-011 Requests arriving outside IDLE SHALL be ignored; interrupts are levels and SHALL remain pending until accepted.
REQ-012 When ena=0, the block SHALL hold state and latches, force cp0_exc, cp0_eret, redirect and flush to 0, and resume the same state when ena returns to 1.
REQ-013 Outside RECORD, cp0_cause and cp0_epc SHALL be 0; outside VECTOR and RETURN, redirect_addr SHALL be 0.
REQ-014 Synchronous exceptions SHALL be accepted even when in_service=1 (nesting is allowed); only interrupts are blocked by in_service.

Reset
REQ-015 While rst=1, the block SHALL be in IDLE with every output at 0, in_service=0, the latched cause/pc at 0 and the irq synchronizer at 0.
REQ-016 Reset asserted mid-sequence (RECORD, VECTOR or RETURN) SHALL abort it immediately, with no strobe issued after rst rises.

Configuration
REQ-017 With macro EXC_CTRL_IRQ_EN defined, irq SHALL pass through a 2-flop synchronizer (irq_sync) and participate per REQ-004, adding 2 cycles of latency from irq to acceptance.
REQ-018 With EXC_CTRL_IRQ_EN undefined, irq, irq_mask and int_en SHALL be ignored, no synchronizer is built, and only brk, sys, teq and eret are handled.

Verification
REQ-019 sys_req=1, pc=32'h0000_0040 in IDLE -> next cycle cp0_exc=1, cp0_cause=5'b01000, cp0_epc=32'h40, flush=1; following cycle redirect=1, redirect_addr=32'h4, in_service=1.
REQ-020 brk_req, sys_req and teq_req all asserted in the same cycle -> single RECORD with cp0_cause=5'b01001.
REQ-021 eret_req=1, epc_in=32'h0000_0044 -> next cycle cp0_eret=1, redirect=1, redirect_addr=32'h44, in_service cleared.
REQ-022 (EXC_CTRL_IRQ_EN) irq=4'b0010, irq_mask=4'b0010, int_en=1 -> cp0_cause=5'b00000 three cycles later; the same stimulus with in_service=1 or irq_mask=0 -> no cp0_exc.
REQ-023 ena=0 held for 3 cycles while in RECORD -> no strobes during the stall; after ena=1, cp0_exc pulses once.
REQ-024 rst pulsed during VECTOR -> redirect=0 immediately, FSM in IDLE, in_service=0.
